// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package interrupt_sequencer_pkg;

  localparam int PC_W = 32;
  localparam int D_W  = 16;

  localparam logic [D_W-1:0] DEFAULT_VEC_ADDR     = 16'h0002;
  localparam int             DEFAULT_DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    VEC_HI,
    VEC_LO,
    LOAD,
    ACK
  } state_t;

endpackage

// File: rtl/interrupt_sequencer_edge_latch.sv
// Rising-edge detector plus one-deep pending flag for the interrupt request line.
// The previous-sample register resets to 1 so a line held high through reset is not an edge.
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clear,
  output logic request
);

  logic prev_reg;
  logic pending_reg;
  logic rise;

  assign rise    = irq & ~prev_reg;
  // The edge itself counts as a request in the same cycle, so an idle sequencer reacts without a latch delay.
  assign request = pending_reg | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg    <= 1'b1;
      pending_reg <= 1'b0;
    end else begin
      prev_reg    <= irq;
      pending_reg <= (pending_reg | rise) & ~clear;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: waits for a safe decode boundary, drains the pipeline,
// pushes the resume PC, saves flags, fetches the handler vector and loads it into fetch.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [D_W-1:0] VEC_ADDR     = DEFAULT_VEC_ADDR,
  parameter int             DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            interrupt,
  input  logic            branch_flush,
  input  logic            id_two_word,
  input  logic [PC_W-1:0] pc_in,
  input  logic [D_W-1:0]  vec_data,
  output logic            stall_fetch,
  output logic            inject_bubble,
  output logic            push_valid,
  output logic [D_W-1:0]  push_data,
  output logic            save_flags,
  output logic            vec_rd,
  output logic [D_W-1:0]  vec_addr,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_value,
  output logic            int_ack,
  output logic            busy
);

  localparam int             CNT_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PC_W-1:0]   resume_pc_reg, resume_pc_next;
  logic [D_W-1:0]    vec_hi_reg, vec_hi_next;
  logic              request;
  logic              start;

  assign start = (state_reg == IDLE) & request & ~id_two_word & ~branch_flush;

  int_edge_latch u_edge (
    .clk     (clk),
    .reset   (reset),
    .irq     (interrupt),
    .clear   (start),
    .request (request)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      resume_pc_reg <= '0;
      vec_hi_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      resume_pc_reg <= resume_pc_next;
      vec_hi_reg    <= vec_hi_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    resume_pc_next = resume_pc_reg;
    vec_hi_next    = vec_hi_reg;
    stall_fetch    = 1'b0;
    inject_bubble  = 1'b0;
    push_valid     = 1'b0;
    push_data      = '0;
    save_flags     = 1'b0;
    vec_rd         = 1'b0;
    vec_addr       = '0;
    pc_load        = 1'b0;
    pc_load_value  = '0;
    int_ack        = 1'b0;

    case (state_reg)
      IDLE: begin
        // Branch resolution and split two-word instructions are unsafe boundaries; retry next cycle.
        if (start) begin
          state_next     = DRAIN;
          cnt_next       = DRAIN_LOAD;
          resume_pc_next = pc_in;
        end
      end
      DRAIN: begin
        stall_fetch   = 1'b1;
        inject_bubble = 1'b1;
        if (cnt_reg == '0) begin
          state_next = PUSH_HI;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PUSH_HI: begin
        stall_fetch   = 1'b1;
        inject_bubble = 1'b1;
        push_valid    = 1'b1;
        push_data     = resume_pc_reg[PC_W-1:D_W];
        save_flags    = 1'b1;
        state_next    = PUSH_LO;
      end
      PUSH_LO: begin
        stall_fetch   = 1'b1;
        inject_bubble = 1'b1;
        push_valid    = 1'b1;
        push_data     = resume_pc_reg[D_W-1:0];
        state_next    = VEC_HI;
      end
      VEC_HI: begin
        stall_fetch   = 1'b1;
        inject_bubble = 1'b1;
        vec_rd        = 1'b1;
        vec_addr      = VEC_ADDR;
        state_next    = VEC_LO;
      end
      VEC_LO: begin
        // Read data arriving now belongs to the high-half read issued in VEC_HI.
        stall_fetch   = 1'b1;
        inject_bubble = 1'b1;
        vec_rd        = 1'b1;
        vec_addr      = VEC_ADDR + D_W'(1);
        vec_hi_next   = vec_data;
        state_next    = LOAD;
      end
      LOAD: begin
        stall_fetch   = 1'b1;
        inject_bubble = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = {vec_hi_reg, vec_data};
        state_next    = ACK;
      end
      ACK: begin
        inject_bubble = 1'b1;
        int_ack       = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed, table-driven bench for interrupt_sequencer with a second instance for vector address wrap.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        push_valid;
    logic [15:0] push_data;
    logic        save_flags;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        int_ack;
    logic        busy;
  } out_t;

  typedef struct {
    string       tag;
    logic        rst;
    logic        irq;
    logic        bf;
    logic        tw;
    logic [31:0] pc;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt;
  logic        branch_flush;
  logic        id_two_word;
  logic [31:0] pc_in;
  logic [15:0] vec_data;
  logic [15:0] w_vec_data;

  logic        stall_fetch, inject_bubble, push_valid, save_flags, vec_rd, pc_load, int_ack, busy;
  logic [15:0] push_data, vec_addr;
  logic [31:0] pc_load_value;

  logic        w_stall_fetch, w_inject_bubble, w_push_valid, w_save_flags, w_vec_rd, w_pc_load, w_int_ack, w_busy;
  logic [15:0] w_push_data, w_vec_addr;
  logic [31:0] w_pc_load_value;

  int checks = 0;
  int fails  = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  interrupt_sequencer u_dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .branch_flush(branch_flush),
    .id_two_word(id_two_word), .pc_in(pc_in), .vec_data(vec_data),
    .stall_fetch(stall_fetch), .inject_bubble(inject_bubble), .push_valid(push_valid),
    .push_data(push_data), .save_flags(save_flags), .vec_rd(vec_rd), .vec_addr(vec_addr),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .int_ack(int_ack), .busy(busy)
  );

  interrupt_sequencer #(.VEC_ADDR(16'hFFFF), .DRAIN_CYCLES(3)) u_wrap (
    .clk(clk), .reset(reset), .interrupt(interrupt), .branch_flush(branch_flush),
    .id_two_word(id_two_word), .pc_in(pc_in), .vec_data(w_vec_data),
    .stall_fetch(w_stall_fetch), .inject_bubble(w_inject_bubble), .push_valid(w_push_valid),
    .push_data(w_push_data), .save_flags(w_save_flags), .vec_rd(w_vec_rd), .vec_addr(w_vec_addr),
    .pc_load(w_pc_load), .pc_load_value(w_pc_load_value), .int_ack(w_int_ack), .busy(w_busy)
  );

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    case (a)
      16'h0002: mem_read = 16'h0000;
      16'h0003: mem_read = 16'h0100;
      16'hFFFF: mem_read = 16'hABCD;
      16'h0000: mem_read = 16'h1234;
      default:  mem_read = a ^ 16'h5A5A;
    endcase
  endfunction

  // Data memory with one-cycle read latency.
  always @(posedge clk) begin
    vec_data   <= mem_read(vec_addr);
    w_vec_data <= mem_read(w_vec_addr);
  end

  function automatic out_t o_idle();
    return '0;
  endfunction
  function automatic out_t o_drain();
    out_t o = '0; o.stall = 1; o.bubble = 1; o.busy = 1; return o;
  endfunction
  function automatic out_t o_phi(input logic [15:0] d);
    out_t o = o_drain(); o.push_valid = 1; o.push_data = d; o.save_flags = 1; return o;
  endfunction
  function automatic out_t o_plo(input logic [15:0] d);
    out_t o = o_drain(); o.push_valid = 1; o.push_data = d; return o;
  endfunction
  function automatic out_t o_vec(input logic [15:0] a);
    out_t o = o_drain(); o.vec_rd = 1; o.vec_addr = a; return o;
  endfunction
  function automatic out_t o_load(input logic [31:0] v);
    out_t o = o_drain(); o.pc_load = 1; o.pc_load_value = v; return o;
  endfunction
  function automatic out_t o_ack();
    out_t o = '0; o.bubble = 1; o.int_ack = 1; o.busy = 1; return o;
  endfunction

  task automatic add(input string tag, input logic rst, input logic irq, input logic bf,
                     input logic tw, input logic [31:0] pc, input out_t e);
    vec_t v;
    v.tag = tag; v.rst = rst; v.irq = irq; v.bf = bf; v.tw = tw; v.pc = pc; v.exp = e;
    tbl.push_back(v);
  endtask

  // Rows for DRAIN through ACK, driving pc_drive while expecting pc_exp to be pushed.
  task automatic add_seq(input string tag, input logic irq, input logic [31:0] pc_drive,
                         input logic [31:0] pc_exp);
    for (int k = 0; k < 3; k++) add(tag, 0, irq, 0, 0, pc_drive, o_drain());
    add(tag, 0, irq, 0, 0, pc_drive, o_phi(pc_exp[31:16]));
    add(tag, 0, irq, 0, 0, pc_drive, o_plo(pc_exp[15:0]));
    add(tag, 0, irq, 0, 0, pc_drive, o_vec(16'h0002));
    add(tag, 0, irq, 0, 0, pc_drive, o_vec(16'h0003));
    add(tag, 0, irq, 0, 0, pc_drive, o_load(32'h0000_0100));
    add(tag, 0, irq, 0, 0, pc_drive, o_ack());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    out_t act;
    int   n;

    // Reset state with interrupt held high: must not fire after release.
    add("reset_hold", 1, 1, 0, 0, 32'h0, o_idle());
    add("reset_hold", 0, 1, 0, 0, 32'h0, o_idle());
    add("reset_hold", 0, 1, 0, 0, 32'h0, o_idle());
    add("reset_hold", 0, 0, 0, 0, 32'h0, o_idle());

    add("basic", 0, 0, 0, 0, 32'h0001_0040, o_idle());
    add("basic", 0, 1, 0, 0, 32'h0001_0040, o_idle());
    add_seq("basic", 1, 32'hDEAD_BEEF, 32'h0001_0040);
    add("basic", 0, 0, 0, 0, 32'h0001_0040, o_idle());

    add("two_word", 0, 1, 0, 1, 32'h1111_1111, o_idle());
    add("two_word", 0, 1, 0, 1, 32'h2222_2222, o_idle());
    add("two_word", 0, 1, 0, 0, 32'h3333_3333, o_idle());
    for (int k = 0; k < 3; k++) add("two_word", 0, 1, 0, 1, 32'h4444_4444, o_drain());
    add("two_word", 0, 1, 1, 1, 32'h4444_4444, o_phi(16'h3333));
    add("two_word", 0, 1, 1, 1, 32'h4444_4444, o_plo(16'h3333));
    add("two_word", 0, 1, 0, 0, 32'h4444_4444, o_vec(16'h0002));
    add("two_word", 0, 1, 0, 0, 32'h4444_4444, o_vec(16'h0003));
    add("two_word", 0, 1, 0, 0, 32'h4444_4444, o_load(32'h0000_0100));
    add("two_word", 0, 1, 0, 0, 32'h4444_4444, o_ack());
    add("two_word", 0, 0, 0, 0, 32'h4444_4444, o_idle());

    add("branch", 0, 1, 1, 0, 32'h0000_0100, o_idle());
    add("branch", 0, 1, 0, 0, 32'h0000_0200, o_idle());
    add_seq("branch", 1, 32'h0000_0300, 32'h0000_0200);
    add("branch", 0, 0, 0, 0, 32'h0000_0300, o_idle());

    add("nested", 0, 1, 0, 0, 32'h0ABC_DEF0, o_idle());
    add("nested", 0, 1, 0, 0, 32'h0ABC_DEF0, o_drain());
    add("nested", 0, 0, 0, 0, 32'h0ABC_DEF0, o_drain());
    add("nested", 0, 0, 0, 0, 32'h0ABC_DEF0, o_drain());
    add("nested", 0, 0, 0, 0, 32'h0ABC_DEF0, o_phi(16'h0ABC));
    add("nested", 0, 1, 0, 0, 32'h0ABC_DEF0, o_plo(16'hDEF0));
    add("nested", 0, 0, 0, 0, 32'h0ABC_DEF0, o_vec(16'h0002));
    add("nested", 0, 1, 0, 0, 32'h0ABC_DEF0, o_vec(16'h0003));
    add("nested", 0, 1, 0, 0, 32'h0ABC_DEF0, o_load(32'h0000_0100));
    add("nested", 0, 1, 0, 0, 32'h0ABC_DEF0, o_ack());
    add("nested", 0, 1, 0, 0, 32'h0555_0666, o_idle());
    add_seq("nested2", 1, 32'h0777_0888, 32'h0555_0666);
    for (int k = 0; k < 3; k++) add("nested_none", 0, 0, 0, 0, 32'h0, o_idle());

    add("rst_mid", 0, 1, 0, 0, 32'h1234_5678, o_idle());
    for (int k = 0; k < 3; k++) add("rst_mid", 0, 1, 0, 0, 32'h1234_5678, o_drain());
    add("rst_mid", 0, 1, 0, 0, 32'h1234_5678, o_phi(16'h1234));
    add("rst_mid", 0, 1, 0, 0, 32'h1234_5678, o_plo(16'h5678));
    add("rst_mid", 1, 1, 0, 0, 32'h1234_5678, o_vec(16'h0002));
    for (int k = 0; k < 3; k++) add("rst_mid", 0, 1, 0, 0, 32'h1234_5678, o_idle());
    add("rst_mid", 0, 0, 0, 0, 32'h1234_5678, o_idle());
    add("rst_mid", 0, 1, 0, 0, 32'h9ABC_0001, o_idle());
    add_seq("rst_mid", 1, 32'h0, 32'h9ABC_0001);
    add("rst_mid", 0, 0, 0, 0, 32'h0, o_idle());

    reset = 1'b1; interrupt = 1'b1; branch_flush = 1'b0; id_two_word = 1'b0; pc_in = '0;
    step();
    step();

    foreach (tbl[i]) begin
      reset        = tbl[i].rst;
      interrupt    = tbl[i].irq;
      branch_flush = tbl[i].bf;
      id_two_word  = tbl[i].tw;
      pc_in        = tbl[i].pc;
      #1;
      act = {stall_fetch, inject_bubble, push_valid, push_data, save_flags, vec_rd, vec_addr,
             pc_load, pc_load_value, int_ack, busy};
      check($sformatf("%s row %0d", tbl[i].tag, i), act, tbl[i].exp);
      step();
    end

    // Vector address wrap on the second instance: VEC_ADDR=FFFF, second read at 0000.
    reset = 1'b0; interrupt = 1'b1; branch_flush = 1'b0; id_two_word = 1'b0; pc_in = 32'h0;
    n = 0;
    #1;
    while (!w_vec_rd && n < 30) begin
      step();
      n++;
    end
    check("wrap latency_to_vec_hi", 72'(n), 72'd6);
    check("wrap vec_addr_hi", 72'({w_vec_rd, w_vec_addr}), 72'({1'b1, 16'hFFFF}));
    step();
    check("wrap vec_addr_lo", 72'({w_vec_rd, w_vec_addr}), 72'({1'b1, 16'h0000}));
    step();
    check("wrap pc_load", 72'({w_pc_load, w_pc_load_value}), 72'({1'b1, 32'hABCD_1234}));
    check("main pc_load", 72'({pc_load, pc_load_value}), 72'({1'b1, 32'h0000_0100}));
    step();
    check("wrap int_ack", 72'({w_int_ack, w_pc_load, w_stall_fetch}), 72'({1'b1, 1'b0, 1'b0}));
    step();
    check("wrap idle", 72'({w_busy, busy}), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
